// File: rtl/vga_draw_arbiter_pkg.sv
// vga_draw_pkg: shared FSM state type and default geometry for the draw arbiter.
package vga_draw_pkg;
    typedef enum logic [1:0] {IDLE, DRAW, DONE, CLEAR} state_t;
    localparam int DEF_H_RES    = 160;
    localparam int DEF_V_RES    = 120;
    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COLOUR_W = 3;
endpackage

// File: rtl/vga_draw_arbiter_if.sv
// vga_draw_arbiter_if: client request bus plus vga_adapter pixel bus of the draw arbiter.
interface vga_draw_arbiter_if #(
    parameter int N_CH     = 4,
    parameter int X_W      = vga_draw_pkg::DEF_X_W,
    parameter int Y_W      = vga_draw_pkg::DEF_Y_W,
    parameter int COLOUR_W = vga_draw_pkg::DEF_COLOUR_W
);
    logic [N_CH-1:0]          req_valid;
    logic [N_CH*X_W-1:0]      req_x;
    logic [N_CH*Y_W-1:0]      req_y;
    logic [N_CH*X_W-1:0]      req_w;
    logic [N_CH*Y_W-1:0]      req_h;
    logic [N_CH*COLOUR_W-1:0] req_colour;
    logic [N_CH-1:0]          req_ready;
    logic [N_CH-1:0]          req_done;
    logic [X_W-1:0]           x;
    logic [Y_W-1:0]           y;
    logic [COLOUR_W-1:0]      colour;
    logic                     plot;
    logic                     busy;
    modport master (
        output req_valid, req_x, req_y, req_w, req_h, req_colour,
        input  req_ready, req_done, x, y, colour, plot, busy
    );
    modport slave (
        input  req_valid, req_x, req_y, req_w, req_h, req_colour,
        output req_ready, req_done, x, y, colour, plot, busy
    );
endinterface

// File: rtl/vga_draw_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int IW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [N_CH-1:0] grant,
    output logic [IW-1:0]   idx
);
    logic [N_CH-1:0] rot;
    logic [IW:0]     sum;
    logic [IW-1:0]   off;
    logic            found;
    always_comb begin
        rot = N_CH'({req, req} >> ptr);
        off = '0;
        found = 1'b0;
        // descending scan so the lowest rotated offset wins
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IW'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= (IW+1)'(N_CH)) ? IW'(sum - (IW+1)'(N_CH)) : sum[IW-1:0];
        grant = found ? N_CH'(1) << idx : '0;
    end
endmodule

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin rectangle-fill arbiter driving vga_adapter one pixel per cycle.
// Define VGA_DRAW_ARB_CLEAR_EN to add a full-screen clear that pre-empts all clients.
module vga_draw_arbiter
    import vga_draw_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COLOUR_W = DEF_COLOUR_W,
    parameter int H_RES    = DEF_H_RES,
    parameter int V_RES    = DEF_V_RES
) (
    input logic clk,
    input logic reset_n,
`ifdef VGA_DRAW_ARB_CLEAR_EN
    input logic                clear_req,
    input logic [COLOUR_W-1:0] clear_colour,
`endif
    vga_draw_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_CH);
    localparam logic [X_W:0] H_LIM = (X_W+1)'(H_RES);
    localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_RES);

    state_t              state, state_n;
    logic [IW-1:0]       ptr, ptr_n, idx;
    logic [N_CH-1:0]     grant, grant_q, grant_n, ready_n, done_n;
    logic [X_W-1:0]      x0, x0_n, w, w_n, dx, dx_n, rx, rw;
    logic [Y_W-1:0]      y0, y0_n, h, h_n, dy, dy_n, ry, rh;
    logic [COLOUR_W-1:0] col, col_n, rcol;
    logic [X_W:0]        px;
    logic [Y_W:0]        py;
    logic                emit, last;

    rr_arbiter #(.N_CH(N_CH), .IW(IW)) u_arb (
        .req(bus.req_valid), .ptr(ptr), .grant(grant), .idx(idx)
    );

    always_comb begin
        state_n = state;
        ptr_n = ptr;
        grant_n = grant_q;
        x0_n = x0;
        y0_n = y0;
        w_n = w;
        h_n = h;
        col_n = col;
        dx_n = dx;
        dy_n = dy;
        emit = 1'b0;
        ready_n = '0;
        done_n = '0;
        rx = bus.req_x[int'(idx)*X_W +: X_W];
        ry = bus.req_y[int'(idx)*Y_W +: Y_W];
        rw = bus.req_w[int'(idx)*X_W +: X_W];
        rh = bus.req_h[int'(idx)*Y_W +: Y_W];
        rcol = bus.req_colour[int'(idx)*COLOUR_W +: COLOUR_W];
        last = (dx == w - 1'b1) && (dy == h - 1'b1);
        case (state)
            IDLE: begin
`ifdef VGA_DRAW_ARB_CLEAR_EN
                if (clear_req) begin
                    state_n = CLEAR;
                    x0_n = '0;
                    y0_n = '0;
                    w_n = X_W'(H_RES);
                    h_n = Y_W'(V_RES);
                    col_n = clear_colour;
                    dx_n = '0;
                    dy_n = '0;
                    emit = 1'b1;
                end else
`endif
                if (|bus.req_valid) begin
                    state_n = (rw == '0 || rh == '0) ? DONE : DRAW;
                    ptr_n = (idx == IW'(N_CH - 1)) ? '0 : idx + 1'b1;
                    grant_n = grant;
                    x0_n = rx;
                    y0_n = ry;
                    w_n = rw;
                    h_n = rh;
                    col_n = rcol;
                    dx_n = '0;
                    dy_n = '0;
                    emit = state_n == DRAW;
                    ready_n = grant;
                    done_n = (state_n == DONE || (rw == X_W'(1) && rh == Y_W'(1))) ? grant : '0;
                end
            end
            DRAW, CLEAR: begin
                if (last) begin
                    state_n = IDLE;
                end else begin
                    dx_n = (dx == w - 1'b1) ? '0 : dx + 1'b1;
                    dy_n = (dx == w - 1'b1) ? dy + 1'b1 : dy;
                    emit = 1'b1;
                    done_n = (state == DRAW && dx_n == w - 1'b1 && dy_n == h - 1'b1) ? grant_q : '0;
                end
            end
            default: state_n = IDLE;
        endcase
        // widened sums so off-screen carries clip instead of wrapping back on-screen
        px = {1'b0, x0_n} + {1'b0, dx_n};
        py = {1'b0, y0_n} + {1'b0, dy_n};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr <= '0;
            grant_q <= '0;
            x0 <= '0;
            y0 <= '0;
            w <= '0;
            h <= '0;
            col <= '0;
            dx <= '0;
            dy <= '0;
            bus.req_ready <= '0;
            bus.req_done <= '0;
            bus.x <= '0;
            bus.y <= '0;
            bus.colour <= '0;
            bus.plot <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            grant_q <= grant_n;
            x0 <= x0_n;
            y0 <= y0_n;
            w <= w_n;
            h <= h_n;
            col <= col_n;
            dx <= dx_n;
            dy <= dy_n;
            bus.req_ready <= ready_n;
            bus.req_done <= done_n;
            bus.plot <= emit && px < H_LIM && py < V_LIM;
            bus.busy <= state_n != IDLE;
            if (emit) begin
                bus.x <= px[X_W-1:0];
                bus.y <= py[Y_W-1:0];
                bus.colour <= col_n;
            end
        end
    end
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter: vector table plus hand sequences, pixels checked against a scoreboard queue.
module tb_vga_draw_arbiter;
    typedef struct {
        int   ch, x, y, w, h, c;
        int   cycles;
        logic first_done;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int checks = 0;
    int errors = 0;
    int done_cnt[4] = '{0, 0, 0, 0};
    logic [17:0] exp_q[$];
    vec_t vecs[7];

    vga_draw_arbiter_if bus ();
`ifdef VGA_DRAW_ARB_CLEAR_EN
    logic       clear_req = 1'b0;
    logic [2:0] clear_colour = 3'd0;
    vga_draw_arbiter dut (.clk(clk), .reset_n(reset_n), .clear_req(clear_req),
                          .clear_colour(clear_colour), .bus(bus));
`else
    vga_draw_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void push_px(input int px, input int py, input int c);
        if (px < 160 && py < 120) exp_q.push_back({8'(px), 7'(py), 3'(c)});
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (bus.req_done[i]) done_cnt[i]++;
        if (bus.plot) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_plot actual x=%0d y=%0d required no plot", bus.x, bus.y);
            end else begin
                chk("pixel", 32'({bus.x, bus.y, bus.colour}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic set_req(input int ch, input int x, input int y, input int w, input int h,
                           input int c, input bit push);
        bus.req_x[ch*8 +: 8] = 8'(x);
        bus.req_y[ch*7 +: 7] = 7'(y);
        bus.req_w[ch*8 +: 8] = 8'(w);
        bus.req_h[ch*7 +: 7] = 7'(h);
        bus.req_colour[ch*3 +: 3] = 3'(c);
        bus.req_valid[ch] = 1'b1;
        if (push) for (int j = 0; j < h; j++) for (int i = 0; i < w; i++) push_px(x + i, y + j, c);
    endtask

    task automatic wait_any(output logic [3:0] r);
        r = '0;
        for (int t = 0; t < 10 && r == '0; t++) begin
            @(negedge clk);
            r = bus.req_ready;
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 100 && bus.busy; t++) @(negedge clk);
        chk("idle_timeout", bus.busy, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] r;
        int cnt, dn, dpos;
        @(negedge clk);
        set_req(v.ch, v.x, v.y, v.w, v.h, v.c, 1'b1);
        wait_any(r);
        chk($sformatf("ready_ch%0d", v.ch), r, 32'(1) << v.ch);
        bus.req_valid = '0;
        chk("done_first", bus.req_done[v.ch], v.first_done);
        cnt = 0;
        dn = 0;
        dpos = 0;
        while (bus.busy && cnt < 300) begin
            cnt++;
            if (bus.req_done[v.ch]) begin
                dn++;
                dpos = cnt;
            end
            @(negedge clk);
        end
        chk("busy_cycles", cnt, v.cycles);
        chk("done_count", dn, 1);
        chk("done_pos", dpos, v.cycles);
    endtask

    initial begin
        logic [3:0] r;
        int gch[5], gt[5], n, g, d2;
        bit reissued;
        vecs[0] = '{0, 10, 20, 3, 2, 5, 6, 1'b0};
        vecs[1] = '{1, 158, 119, 4, 2, 3, 8, 1'b0};
        vecs[2] = '{2, 5, 5, 0, 5, 1, 1, 1'b1};
        vecs[3] = '{3, 0, 0, 1, 1, 7, 1, 1'b1};
        vecs[4] = '{1, 250, 10, 10, 1, 2, 10, 1'b0};
        vecs[5] = '{2, 100, 118, 2, 3, 4, 6, 1'b0};
        vecs[6] = '{0, 7, 7, 3, 0, 6, 1, 1'b1};
        reset_n = 1'b0;
        bus.req_valid = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.req_w = '0;
        bus.req_h = '0;
        bus.req_colour = '0;
        repeat (2) @(negedge clk);
        chk("rst_plot", bus.plot, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_done", bus.req_done, 0);
        chk("rst_xyc", {bus.x, bus.y, bus.colour}, 0);
        reset_n = 1'b1;
        foreach (vecs[i]) run_vec(vecs[i]);

        // all four channels at once from a fresh pointer; ch0 re-requests after its done
        pulse_reset();
        for (int c = 0; c < 4; c++) set_req(c, c * 2, 5, 1, 1, c + 1, 1'b1);
        n = 0;
        reissued = 0;
        for (int t = 0; t < 40 && n < 5; t++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                chk("grant_onehot", $onehot(bus.req_ready), 1);
                g = 0;
                for (int i = 0; i < 4; i++) if (bus.req_ready[i]) g = i;
                gch[n] = g;
                gt[n] = t;
                n++;
                bus.req_valid[g] = 1'b0;
                if (g == 0 && !reissued) begin
                    reissued = 1;
                    set_req(0, 60, 7, 1, 1, 6, 1'b1);
                end
            end
        end
        chk("grant_count", n, 5);
        for (int i = 0; i < 5 && i < n; i++) chk($sformatf("grant_order%0d", i), gch[i], i % 4);
        for (int i = 1; i < 5 && i < n; i++) chk($sformatf("grant_gap%0d", i), gt[i] - gt[i-1], 2);
        wait_idle();

        // reset in the middle of a 4x4 rectangle
        @(negedge clk);
        d2 = done_cnt[2];
        set_req(2, 30, 40, 4, 4, 2, 1'b0);
        push_px(30, 40, 2);
        push_px(31, 40, 2);
        push_px(32, 40, 2);
        wait_any(r);
        chk("mid_ready", r, 4'b0100);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        chk("mid_plot3", {bus.plot, bus.x}, {1'b1, 8'd32});
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_plot", bus.plot, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_xyc", {bus.x, bus.y, bus.colour}, 0);
        chk("mid_rst_rd", {bus.req_ready, bus.req_done}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("mid_no_done", done_cnt[2] - d2, 0);
        set_req(1, 3, 3, 1, 1, 5, 1'b1);
        set_req(3, 4, 4, 1, 1, 6, 1'b1);
        wait_any(r);
        chk("post_rst_first", r, 4'b0010);
        bus.req_valid[1] = 1'b0;
        wait_any(r);
        chk("post_rst_second", r, 4'b1000);
        bus.req_valid[3] = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
